// File: rtl/word_deserializer_if.sv
// Symbol-in / word-out handshake bundle for word_deserializer.
interface word_deserializer_if #(
  parameter int SYM_W = 8,
  parameter int SYMS  = 4
);
  logic                    sym_valid_i;
  logic                    sym_ready_o;
  logic                    sof_i;
  logic [SYM_W-1:0]        sym_i;
  logic                    word_valid_o;
  logic                    word_ready_i;
  logic [SYMS*SYM_W-1:0]   word_o;

  modport master (
    output sym_valid_i, sof_i, sym_i, word_ready_i,
    input  sym_ready_o, word_valid_o, word_o
  );

  modport slave (
    input  sym_valid_i, sof_i, sym_i, word_ready_i,
    output sym_ready_o, word_valid_o, word_o
  );
endinterface

// File: rtl/word_deserializer.sv
// Packs SYMS symbols of SYM_W bits into one word with valid/ready on both
// sides; reports short-word and orphan-symbol framing errors as pulses.
module word_deserializer #(
  parameter int SYM_W     = 8,
  parameter int SYMS      = 4,
  parameter int MSB_FIRST = 1,
  parameter int AUTO_SOF  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  word_deserializer_if.slave  bus,
  output logic                err_short_o,
  output logic                err_orphan_o
);

  localparam int WORD_W = SYMS * SYM_W;
  localparam int CNT_W  = $clog2(SYMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMS - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                wv_q, wv_d;
  logic                es_q, es_d;
  logic                eo_q, eo_d;
  logic                accept;

  // Drop one symbol into its slot position within a word image.
  function automatic logic [WORD_W-1:0] put(input logic [WORD_W-1:0] base,
                                            input logic [SYM_W-1:0]  s,
                                            input logic [CNT_W-1:0]  slot);
    put = base;
    for (int unsigned k = 0; k < SYMS; k++) begin
      if (slot == CNT_W'(k)) begin
        put[((MSB_FIRST != 0) ? (SYMS - 1 - k) : k) * SYM_W +: SYM_W] = s;
      end
    end
  endfunction

  assign bus.sym_ready_o  = !wv_q | bus.word_ready_i;
  assign accept           = bus.sym_valid_i & bus.sym_ready_o;
  assign bus.word_valid_o = wv_q;
  assign bus.word_o       = word_q;
  assign err_short_o      = es_q;
  assign err_orphan_o     = eo_q;

  // Next-state, accumulation, word load and error detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    word_d  = word_q;
    wv_d    = wv_q;
    es_d    = 1'b0;
    eo_d    = 1'b0;
    if (wv_q && bus.word_ready_i) begin
      wv_d = 1'b0;
    end
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (bus.sof_i || (AUTO_SOF != 0)) begin
            acc_d   = put(acc_q, bus.sym_i, '0);
            cnt_d   = CNT_W'(1);
            state_d = COLLECT;
          end else begin
            eo_d = 1'b1;
          end
        end
        COLLECT: begin
          if (bus.sof_i) begin
            es_d  = 1'b1;
            acc_d = put(acc_q, bus.sym_i, '0);
            cnt_d = CNT_W'(1);
          end else if (cnt_q == LAST) begin
            // A load here overrides the handshake clear above, so a
            // back-to-back word keeps word_valid_o high with no bubble.
            word_d  = put(acc_q, bus.sym_i, LAST);
            wv_d    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d = put(acc_q, bus.sym_i, cnt_q);
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      word_q  <= '0;
      wv_q    <= 1'b0;
      es_q    <= 1'b0;
      eo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      wv_q    <= wv_d;
      es_q    <= es_d;
      eo_q    <= eo_d;
    end
  end

endmodule

// File: tb/tb_word_deserializer.sv
// Bench for word_deserializer: three parameterisations share one stimulus
// stream and are compared every cycle against a symbol-list reference model.
module tb_word_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sv = 1'b0;
  logic       sof = 1'b0;
  logic       wr = 1'b0;
  logic [9:0] sym = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  word_deserializer_if #(.SYM_W(8),  .SYMS(4)) ifa ();
  word_deserializer_if #(.SYM_W(8),  .SYMS(4)) ifb ();
  word_deserializer_if #(.SYM_W(10), .SYMS(3)) ifc ();

  logic es_a, eo_a, es_b, eo_b, es_c, eo_c;

  assign ifa.sym_valid_i = sv;  assign ifa.sof_i = sof;
  assign ifa.sym_i = sym[7:0];  assign ifa.word_ready_i = wr;
  assign ifb.sym_valid_i = sv;  assign ifb.sof_i = sof;
  assign ifb.sym_i = sym[7:0];  assign ifb.word_ready_i = wr;
  assign ifc.sym_valid_i = sv;  assign ifc.sof_i = sof;
  assign ifc.sym_i = sym;       assign ifc.word_ready_i = wr;

  word_deserializer #(.SYM_W(8), .SYMS(4), .MSB_FIRST(1), .AUTO_SOF(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .err_short_o(es_a), .err_orphan_o(eo_a));
  word_deserializer #(.SYM_W(8), .SYMS(4), .MSB_FIRST(0), .AUTO_SOF(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .err_short_o(es_b), .err_orphan_o(eo_b));
  word_deserializer #(.SYM_W(10), .SYMS(3), .MSB_FIRST(1), .AUTO_SOF(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave), .err_short_o(es_c), .err_orphan_o(eo_c));

  // Gathered DUT outputs, index 0/1/2 = dut_a/b/c.
  logic [31:0] a_word [3];
  logic        a_rdy  [3];
  logic        a_wv   [3];
  logic        a_es   [3];
  logic        a_eo   [3];

  assign a_word[0] = ifa.word_o;  assign a_word[1] = ifb.word_o;
  assign a_word[2] = {2'b00, ifc.word_o};
  assign a_rdy[0] = ifa.sym_ready_o;  assign a_rdy[1] = ifb.sym_ready_o;
  assign a_rdy[2] = ifc.sym_ready_o;
  assign a_wv[0] = ifa.word_valid_o;  assign a_wv[1] = ifb.word_valid_o;
  assign a_wv[2] = ifc.word_valid_o;
  assign a_es[0] = es_a;  assign a_es[1] = es_b;  assign a_es[2] = es_c;
  assign a_eo[0] = eo_a;  assign a_eo[1] = eo_b;  assign a_eo[2] = eo_c;

  // Reference model: a list of collected symbols per instance; a word is
  // formed arithmetically once the list holds SYMS entries.
  localparam int unsigned MW   [3] = '{8, 8, 10};
  localparam int unsigned MN   [3] = '{4, 4, 3};
  localparam bit          MMSB [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit          MAUTO[3] = '{1'b0, 1'b1, 1'b1};

  int unsigned m_buf [3][4];
  int unsigned m_cnt [3];
  int unsigned m_word[3];
  bit          m_wv  [3];
  bit          m_es  [3];
  bit          m_eo  [3];

  task automatic model_step(input int d);
    bit          rdy;
    int unsigned s;
    int unsigned w;
    rdy = !m_wv[d] || wr;
    s   = int'(sym) & ((1 << MW[d]) - 1);
    m_es[d] = 1'b0;
    m_eo[d] = 1'b0;
    if (!rst_n) begin
      m_wv[d] = 1'b0; m_word[d] = 0; m_cnt[d] = 0;
    end else begin
      if (m_wv[d] && wr) m_wv[d] = 1'b0;
      if (sv && rdy) begin
        if (sof || (m_cnt[d] == 0 && MAUTO[d])) begin
          if (m_cnt[d] != 0) m_es[d] = 1'b1;
          m_buf[d][0] = s;
          m_cnt[d] = 1;
        end else if (m_cnt[d] == 0) begin
          m_eo[d] = 1'b1;
        end else begin
          m_buf[d][m_cnt[d]] = s;
          m_cnt[d]++;
          if (m_cnt[d] == MN[d]) begin
            w = 0;
            for (int k = 0; k < int'(MN[d]); k++) begin
              if (MMSB[d]) w = (w << MW[d]) | m_buf[d][k];
              else         w = w | (m_buf[d][k] << (k * MW[d]));
            end
            m_word[d] = w;
            m_wv[d]   = 1'b1;
            m_cnt[d]  = 0;
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) model_step(d);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rdy%0d", d),  32'(a_rdy[d]), 32'(!m_wv[d] || wr));
      chk($sformatf("wv%0d", d),   32'(a_wv[d]),  32'(m_wv[d]));
      chk($sformatf("word%0d", d), a_word[d],     m_word[d]);
      chk($sformatf("es%0d", d),   32'(a_es[d]),  32'(m_es[d]));
      chk($sformatf("eo%0d", d),   32'(a_eo[d]),  32'(m_eo[d]));
    end
  end

  task automatic drive(input bit v, input bit s, input logic [9:0] dat, input bit r);
    @(posedge clk); #1;
    sv = v; sof = s; sym = dat; wr = r;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    sv = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    wr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("lit_reset_wv", 32'(a_wv[0]), 32'h0);
    chk("lit_reset_word", a_word[0], 32'h0);
    rst_n = 1'b1;

    // Basic stream with continuous downstream ready.
    drive(1, 1, 10'h11, 1); drive(1, 0, 10'h22, 1);
    drive(1, 0, 10'h33, 1); drive(1, 0, 10'h44, 1);
    drive(0, 0, 10'h0, 1);
    chk("lit_a_wv", 32'(a_wv[0]), 32'h1);
    chk("lit_a_word", a_word[0], 32'h11223344);
    chk("lit_b_word", a_word[1], 32'h44332211);
    chk("lit_model_a", m_word[0], 32'h11223344);
    drive(0, 0, 10'h0, 1);
    chk("lit_a_wv_clr", 32'(a_wv[0]), 32'h0);
    chk("lit_a_word_kept", a_word[0], 32'h11223344);

    // Early sof aborts a partial word.
    drive(1, 1, 10'hAA, 1); drive(1, 0, 10'hBB, 1);
    drive(1, 1, 10'h01, 1); drive(1, 0, 10'h02, 1);
    chk("lit_a_short", 32'(a_es[0]), 32'h1);
    drive(1, 0, 10'h03, 1);
    chk("lit_a_short_end", 32'(a_es[0]), 32'h0);
    drive(1, 0, 10'h04, 1); drive(0, 0, 10'h0, 1);
    chk("lit_a_word_short", a_word[0], 32'h01020304);
    chk("lit_b_word_short", a_word[1], 32'h04030201);

    // Orphan symbol in IDLE without sof.
    drive(0, 0, 10'h0, 1);
    drive(1, 0, 10'h55, 1); drive(0, 0, 10'h0, 1);
    chk("lit_a_orphan", 32'(a_eo[0]), 32'h1);
    chk("lit_a_orphan_nowv", 32'(a_wv[0]), 32'h0);

    // Framing-free start.
    pulse_reset();
    drive(1, 0, 10'h55, 1); drive(1, 0, 10'h66, 1);
    drive(1, 0, 10'h77, 1); drive(1, 0, 10'h88, 1);
    drive(0, 0, 10'h0, 1);
    chk("lit_b_auto", a_word[1], 32'h88776655);
    chk("lit_b_auto_wv", 32'(a_wv[1]), 32'h1);

    // Reset in the middle of a word.
    pulse_reset();
    drive(1, 1, 10'h11, 1); drive(1, 0, 10'h22, 1);
    pulse_reset();
    chk("lit_rst_es", 32'(a_es[0]), 32'h0);
    chk("lit_rst_word", a_word[0], 32'h0);
    drive(1, 1, 10'hA1, 1); drive(1, 0, 10'hB2, 1);
    drive(1, 0, 10'hC3, 1); drive(1, 0, 10'hD4, 1);
    drive(0, 0, 10'h0, 1);
    chk("lit_after_rst", a_word[0], 32'hA1B2C3D4);

    // 10-bit, 3-symbol instance.
    pulse_reset();
    drive(1, 1, 10'h3FF, 1); drive(1, 0, 10'h001, 1); drive(1, 0, 10'h2AA, 1);
    drive(0, 0, 10'h0, 1);
    chk("lit_c_word", a_word[2], 32'h3FF006AA);
    chk("lit_model_c", m_word[2], 32'h3FF006AA);

    // Backpressure: completed word held while next symbols are offered.
    pulse_reset();
    drive(1, 1, 10'h11, 0); drive(1, 0, 10'h22, 0);
    drive(1, 0, 10'h33, 0); drive(1, 0, 10'h44, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 10'h55, 0);
      chk("lit_bp_rdy", 32'(a_rdy[0]), 32'h0);
      chk("lit_bp_word", a_word[0], 32'h11223344);
    end
    drive(1, 1, 10'h55, 1); drive(1, 0, 10'h66, 1);
    drive(1, 0, 10'h77, 1); drive(1, 0, 10'h88, 1);
    drive(0, 0, 10'h0, 1);
    chk("lit_bp_next", a_word[0], 32'h55667788);

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      sv    = ($urandom_range(0, 9) < 7);
      sof   = ($urandom_range(0, 9) < 2);
      wr    = ($urandom_range(0, 9) < 6);
      sym   = 10'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
